// File: rtl/clock_control_if.sv
// ---------------------------------------------------------------------------
// clock_control_if
// Bundles the operator-panel inputs and the clock-generator control outputs
// of clock_control. Clock and reset are plain module ports, not part of this
// bundle.
//
// Signal semantics: there is no valid/ready handshake here. Every input is
// a level: the three buttons are raw and asynchronous, and i_HLT_INSTR is
// synchronous to i_SYS_CLOCK. Every output is a registered level, except
// o_STEP_TOGGLE and o_STEP_CLOCK, which are registered pulses whose widths
// are counted in system-clock cycles.
//
//   i_BTN_MODE    raw mode button (1 = pressed)
//   i_BTN_STEP    raw single-step button (1 = pressed)
//   i_BTN_HALT    raw halt/resume button (1 = pressed)
//   i_HLT_INSTR   CPU halt-instruction level
//   o_STEP_TOGGLE mode-toggle pulse to the clock generator
//   o_STEP_CLOCK  manual step clock to the clock generator
//   o_HALT        halt level to the clock generator
//   o_MANUAL      manual-step state mirror (1 = manual)
//   o_STEP_STATE  debug view of the step FSM state (0 idle, 1 high, 2 guard)
// ---------------------------------------------------------------------------
interface clock_control_if;
    logic       i_BTN_MODE;
    logic       i_BTN_STEP;
    logic       i_BTN_HALT;
    logic       i_HLT_INSTR;
    logic       o_STEP_TOGGLE;
    logic       o_STEP_CLOCK;
    logic       o_HALT;
    logic       o_MANUAL;
    logic [1:0] o_STEP_STATE;

    modport master (
        output i_BTN_MODE, i_BTN_STEP, i_BTN_HALT, i_HLT_INSTR,
        input  o_STEP_TOGGLE, o_STEP_CLOCK, o_HALT, o_MANUAL, o_STEP_STATE
    );

    modport slave (
        input  i_BTN_MODE, i_BTN_STEP, i_BTN_HALT, i_HLT_INSTR,
        output o_STEP_TOGGLE, o_STEP_CLOCK, o_HALT, o_MANUAL, o_STEP_STATE
    );
endinterface

// File: rtl/clock_control.sv
// ---------------------------------------------------------------------------
// clock_control
// Operator-panel front end for the CPU clock generator. Each of the three
// buttons goes through a synchronizer and a debouncer, and each debounced
// press becomes a one-cycle event. The events then drive three things:
//   - mode:  toggles manual/auto and emits a STEP_CYCLES-wide toggle pulse
//   - step:  in manual mode and while not halted, emits one step-clock pulse
//            (STEP_CYCLES high), followed by a STEP_CYCLES guard time
//   - halt:  a latch that is set by i_HLT_INSTR or by a press, and cleared
//            by a press
// Every output comes from a flop.
//
// Ports:
//   i_SYS_CLOCK  system clock; all logic runs on its rising edge
//   i_RESET      asynchronous, active-high reset
//   bus          clock_control_if.slave (buttons, halt instruction, outputs)
// ---------------------------------------------------------------------------
module clock_control #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int STEP_CYCLES     = 1000
) (
    input  logic            i_SYS_CLOCK,
    input  logic            i_RESET,
    clock_control_if.slave  bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

    // Button index: 0 = mode, 1 = step, 2 = halt.
    logic [2:0] raw_btn;
    logic [2:0] press;

    assign raw_btn = {bus.i_BTN_HALT, bus.i_BTN_STEP, bus.i_BTN_MODE};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        logic          sync1;
        logic          sync2;
        logic          deb;
        logic          deb_d;
        logic          ev;
        logic [DW-1:0] cnt;

        // The flip happens on the DEBOUNCE_CYCLES-th consecutive mismatch.
        // The press event is registered one cycle after the flip, so that a
        // clean edge is reported DEBOUNCE_CYCLES+3 edges after it occurs.
        always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
            if (i_RESET) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                deb   <= 1'b0;
                deb_d <= 1'b0;
                ev    <= 1'b0;
                cnt   <= '0;
            end else begin
                sync1 <= raw_btn[g];
                sync2 <= sync1;
                deb_d <= deb;
                ev    <= deb & ~deb_d;
                if (sync2 == deb) begin
                    cnt <= '0;
                end else if (cnt == DB_LAST) begin
                    deb <= ~deb;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + DW'(1);
                end
            end
        end

        assign press[g] = ev;
    end

    wire mode_press = press[0];
    wire step_press = press[1];
    wire halt_press = press[2];

    // Mode toggle. A press is ignored while the toggle pulse is still high,
    // and in that case o_MANUAL does not toggle either.
    logic          toggle_q;
    logic          manual_q;
    logic [SW-1:0] tcnt;

    always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
        if (i_RESET) begin
            toggle_q <= 1'b0;
            manual_q <= 1'b0;
            tcnt     <= '0;
        end else if (toggle_q) begin
            if (tcnt == STEP_LAST) begin
                toggle_q <= 1'b0;
                tcnt     <= '0;
            end else begin
                tcnt <= tcnt + SW'(1);
            end
        end else if (mode_press) begin
            toggle_q <= 1'b1;
            tcnt     <= '0;
            manual_q <= ~manual_q;
        end
    end

    // Halt latch. When a set and a clear happen in the same cycle, set wins.
    logic halt_q;
    wire  halt_set = bus.i_HLT_INSTR | (halt_press & ~halt_q);
    wire  halt_clr = halt_press & halt_q & ~bus.i_HLT_INSTR;

    always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
        if (i_RESET) begin
            halt_q <= 1'b0;
        end else if (halt_set) begin
            halt_q <= 1'b1;
        end else if (halt_clr) begin
            halt_q <= 1'b0;
        end
    end

    // Step FSM. The FSM reads the registered manual_q and halt_q, so a step
    // press that arrives in the same cycle as a mode press sees the manual
    // value from before the toggle. Presses that arrive outside IDLE are
    // dropped. A sequence that has started always runs to completion.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_GUARD = 2'd2
    } step_state_t;

    step_state_t   state;
    logic [SW-1:0] scnt;
    logic          step_clk_q;

    always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
        if (i_RESET) begin
            state      <= ST_IDLE;
            scnt       <= '0;
            step_clk_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (step_press && manual_q && !halt_q) begin
                        state      <= ST_HIGH;
                        scnt       <= '0;
                        step_clk_q <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (scnt == STEP_LAST) begin
                        state      <= ST_GUARD;
                        scnt       <= '0;
                        step_clk_q <= 1'b0;
                    end else begin
                        scnt <= scnt + SW'(1);
                    end
                end
                ST_GUARD: begin
                    if (scnt == STEP_LAST) begin
                        state <= ST_IDLE;
                        scnt  <= '0;
                    end else begin
                        scnt <= scnt + SW'(1);
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    scnt       <= '0;
                    step_clk_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_STEP_TOGGLE = toggle_q;
    assign bus.o_STEP_CLOCK  = step_clk_q;
    assign bus.o_HALT        = halt_q;
    assign bus.o_MANUAL      = manual_q;
    assign bus.o_STEP_STATE  = state;
endmodule
